// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response channel, decode handshake and redirect inputs.
// The master modport is the fetch unit's view; slave is the surrounding pipeline/memory view.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [1:0]  pc_select;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
             redirect_valid, pc_select, branch_target, jalr_target
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
             redirect_valid, pc_select, branch_target, jalr_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers returned words with their PCs for decode, and squashes wrong-path fetches on redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned DCW = 16;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [31:0]    fetch_pc;
   cnt_t           outstanding;
   cnt_t           count;
   logic [DCW-1:0] drop_cnt;
   ptr_t           pcf_wr, pcf_rd;
   ptr_t           buf_wr, buf_rd;
   logic [31:0]    pc_fifo  [DEPTH];
   logic [31:0]    buf_inst [DEPTH];
   logic [31:0]    buf_pc   [DEPTH];

   logic           redirect_now;
   logic [31:0]    redirect_pc;
   logic           credit_ok;
   logic           req_valid;
   logic           req_fire;
   logic           rsp_drop;
   logic           rsp_live;
   logic           push;
   logic           pop;
   logic           have_inst;
   logic [DCW-1:0] drop_next;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   always_comb begin
      redirect_now = bus.redirect_valid &&
                     (bus.pc_select == 2'b01 || bus.pc_select == 2'b10);
      redirect_pc  = ((bus.pc_select == 2'b01) ? bus.branch_target : bus.jalr_target)
                     & ~32'h0000_0003;
      credit_ok    = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(DEPTH);
      req_valid    = !rst && !redirect_now && credit_ok;
      req_fire     = req_valid && bus.imem_req_ready;
      // Dropped words come from requests squashed earlier and are not counted as outstanding.
      rsp_drop     = bus.imem_rsp_valid && (drop_cnt != '0);
      rsp_live     = bus.imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
      have_inst    = (count != '0);
      push         = !rst && rsp_live && !redirect_now;
      pop          = !rst && have_inst && bus.inst_ready && !redirect_now;
      // Everything still in flight at a redirect becomes wrong-path, minus a word landing this cycle.
      drop_next    = drop_cnt - DCW'(rsp_drop) + DCW'(outstanding) - DCW'(rsp_live);
   end

   always_comb begin
      bus.imem_req_valid = req_valid;
      bus.imem_req_addr  = fetch_pc;
      bus.inst_valid     = have_inst;
      bus.inst           = have_inst ? buf_inst[buf_rd] : '0;
      bus.inst_pc        = have_inst ? buf_pc[buf_rd]   : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         count       <= '0;
         drop_cnt    <= '0;
         pcf_wr      <= '0;
         pcf_rd      <= '0;
         buf_wr      <= '0;
         buf_rd      <= '0;
      end else if (redirect_now) begin
         fetch_pc    <= redirect_pc;
         outstanding <= '0;
         count       <= '0;
         drop_cnt    <= drop_next;
         pcf_wr      <= '0;
         pcf_rd      <= '0;
         buf_wr      <= '0;
         buf_rd      <= '0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            pcf_wr   <= ptr_inc(pcf_wr);
         end
         if (rsp_drop) begin
            drop_cnt <= drop_cnt - DCW'(1);
         end
         if (rsp_live) begin
            pcf_rd <= ptr_inc(pcf_rd);
         end
         if (push) begin
            buf_wr <= ptr_inc(buf_wr);
         end
         if (pop) begin
            buf_rd <= ptr_inc(buf_rd);
         end
         outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_live);
         count       <= count + cnt_t'(push) - cnt_t'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) begin
         pc_fifo[pcf_wr] <= fetch_pc;
      end
      if (push) begin
         buf_inst[buf_wr] <= bus.imem_rsp_data;
         buf_pc[buf_wr]   <= pc_fifo[pcf_rd];
      end
   end

   // A response with nothing in flight means imem broke the request/response pairing.
   rsp_has_request: assert property (@(posedge clk) disable iff (rst)
      bus.imem_rsp_valid |-> (outstanding != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order imem model with programmable latency, and a decode-side
// scoreboard holding the expected (pc, word) stream that every consumed instruction must match.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data  = '0;
   logic        tb_redirect;

   int unsigned total    = 0;
   int unsigned bad      = 0;
   int unsigned lat      = 1;
   int unsigned cyc      = 0;
   int unsigned fire_cnt = 0;
   int unsigned pop_cnt  = 0;
   int unsigned base;

   exp_t        exp_q [$];
   exp_t        mon_e;
   logic [31:0] pa_q  [$];
   int unsigned pd_q  [$];

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_rsp_valid = rsp_valid;
   assign bus.imem_rsp_data  = rsp_data;
   assign tb_redirect = bus.redirect_valid && (bus.pc_select == 2'b01 || bus.pc_select == 2'b10);

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, want);
      end
   endtask

   task automatic set_stream(input logic [31:0] start);
      exp_t e;
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         e.pc   = start + 32'(4 * i);
         e.word = mem_word(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset(input int unsigned latency);
      @(negedge clk);
      rst = 1'b1;
      lat = latency;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      set_stream(RESET_PC);
   endtask

   task automatic wait_inst(input string tag, input int unsigned budget);
      int unsigned n = 0;
      while (bus.inst_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      total++;
      assert (bus.inst_valid === 1'b1) else begin
         bad++;
         $error("FAIL %s observed=timeout expected=inst_valid", tag);
      end
   endtask

   // In-order instruction memory: each accepted request answers lat cycles later.
   always @(posedge clk) begin
      if (rst) begin
         pa_q.delete();
         pd_q.delete();
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
         pa_q.push_back(bus.imem_req_addr);
         pd_q.push_back(cyc + lat);
         fire_cnt++;
      end
      cyc++;
      #1;
      if (pa_q.size() != 0 && pd_q[0] <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = mem_word(pa_q[0]);
         void'(pa_q.pop_front());
         void'(pd_q.pop_front());
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
   end

   // Decode side: every consumed instruction must be the next one on the correct path.
   always @(posedge clk) begin
      if (!rst && bus.inst_valid && bus.inst_ready && !tb_redirect) begin
         pop_cnt++;
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL dec_unexpected observed=%h expected=none", bus.inst_pc);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("dec_pc", bus.inst_pc, mon_e.pc);
            chk("dec_inst", bus.inst, mon_e.word);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.pc_select      = 2'b00;
      bus.branch_target  = '0;
      bus.jalr_target    = '0;

      // Reset state and sequential fetch with a 1-cycle memory
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
      chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
      chk1("rst_inst_valid", bus.inst_valid, 1'b0);
      chk("rst_inst", bus.inst, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      set_stream(RESET_PC);
      #1;
      chk1("t1_c0_valid", bus.imem_req_valid, 1'b1);
      chk("t1_c0_addr", bus.imem_req_addr, 32'h0);
      @(negedge clk); #1;
      chk1("t1_c1_valid", bus.imem_req_valid, 1'b1);
      chk("t1_c1_addr", bus.imem_req_addr, 32'h4);
      @(negedge clk); #1;
      chk1("t1_c2_inst_valid", bus.inst_valid, 1'b1);
      chk("t1_c2_inst_pc", bus.inst_pc, 32'h0);
      chk("t1_c2_inst", bus.inst, 32'h0000_0013);
      chk1("t1_c2_credit_block", bus.imem_req_valid, 1'b0);
      chk("t1_c2_addr", bus.imem_req_addr, 32'h8);
      @(negedge clk); #1;
      chk1("t1_c3_valid", bus.imem_req_valid, 1'b1);
      chk("t1_c3_addr", bus.imem_req_addr, 32'h8);

      // Decode stalled: credits cap fetches at two, one pop frees one credit
      bus.inst_ready = 1'b0;
      do_reset(1);
      base = fire_cnt;
      repeat (8) @(negedge clk);
      #1;
      chk("t2_fire_count", 32'(fire_cnt - base), 32'd2);
      chk1("t2_req_blocked", bus.imem_req_valid, 1'b0);
      chk1("t2_inst_valid", bus.inst_valid, 1'b1);
      chk("t2_head_pc", bus.inst_pc, 32'h0);
      @(negedge clk);
      bus.inst_ready = 1'b1;
      #1;
      chk1("t2_pop_cycle_valid", bus.imem_req_valid, 1'b0);

      // imem not ready: request held at 0x8 until accepted
      @(negedge clk);
      bus.imem_req_ready = 1'b0;
      #1;
      chk1("t2_credit_valid", bus.imem_req_valid, 1'b1);
      chk("t2_credit_addr", bus.imem_req_addr, 32'h8);
      base = fire_cnt;
      repeat (4) begin
         @(negedge clk); #1;
         chk1("t3_hold_valid", bus.imem_req_valid, 1'b1);
         chk("t3_hold_addr", bus.imem_req_addr, 32'h8);
      end
      chk("t3_no_fire", 32'(fire_cnt - base), 32'd0);
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      #1;
      chk("t3_resume_addr", bus.imem_req_addr, 32'h8);
      @(negedge clk); #1;
      chk1("t3_next_valid", bus.imem_req_valid, 1'b1);
      chk("t3_next_addr", bus.imem_req_addr, 32'hC);

      // Branch redirect with two requests in flight on a 3-cycle memory
      do_reset(3);
      #1;
      chk("t4_c0_addr", bus.imem_req_addr, 32'h0);
      @(negedge clk); #1;
      chk("t4_c1_addr", bus.imem_req_addr, 32'h4);
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.pc_select      = 2'b01;
      bus.branch_target  = 32'h0000_0100;
      set_stream(32'h0000_0100);
      #1;
      chk1("t4_r_no_req", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.pc_select      = 2'b00;
      #1;
      chk1("t4_r1_inst_valid", bus.inst_valid, 1'b0);
      chk1("t4_r1_valid", bus.imem_req_valid, 1'b1);
      chk("t4_r1_addr", bus.imem_req_addr, 32'h0000_0100);
      wait_inst("t4_wait", 20);
      chk("t4_first_pc", bus.inst_pc, 32'h0000_0100);
      chk("t4_first_inst", bus.inst, mem_word(32'h0000_0100));

      // JALR target is word-aligned; pc_select 11 with redirect_valid does nothing
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.pc_select      = 2'b10;
      bus.jalr_target    = 32'h0000_0203;
      set_stream(32'h0000_0200);
      #1;
      chk1("t4_jalr_no_req", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      bus.pc_select     = 2'b11;
      bus.branch_target = 32'h0000_0500;
      bus.jalr_target   = 32'h0000_0600;
      #1;
      chk1("t4_jalr_inst_valid", bus.inst_valid, 1'b0);
      chk1("t4_sel11_valid", bus.imem_req_valid, 1'b1);
      chk("t4_jalr_addr", bus.imem_req_addr, 32'h0000_0200);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.pc_select      = 2'b00;
      #1;
      chk("t4_sel11_next_addr", bus.imem_req_addr, 32'h0000_0204);
      wait_inst("t4_jalr_wait", 30);
      chk("t4_jalr_pc", bus.inst_pc, 32'h0000_0200);

      // Redirect in the same cycle as a live response and a decode pop
      do_reset(1);
      @(negedge clk); #1;
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.pc_select      = 2'b01;
      bus.branch_target  = 32'h0000_0302;
      set_stream(32'h0000_0300);
      #1;
      chk1("t5_r_inst_valid", bus.inst_valid, 1'b1);
      chk1("t5_r_no_req", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.pc_select      = 2'b00;
      #1;
      chk1("t5_flushed", bus.inst_valid, 1'b0);
      chk("t5_flushed_inst", bus.inst, 32'h0);
      chk("t5_flushed_pc", bus.inst_pc, 32'h0);
      chk("t5_r1_addr", bus.imem_req_addr, 32'h0000_0300);
      @(negedge clk); #1;
      chk1("t5_r2_empty", bus.inst_valid, 1'b0);
      @(negedge clk); #1;
      chk1("t5_r3_valid", bus.inst_valid, 1'b1);
      chk("t5_r3_pc", bus.inst_pc, 32'h0000_0300);
      chk("t5_r3_inst", bus.inst, mem_word(32'h0000_0300));

      // PC wrap at the top of the address space, then reset mid-stream
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.pc_select      = 2'b10;
      bus.jalr_target    = 32'hFFFF_FFFF;
      set_stream(32'hFFFF_FFFC);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.pc_select      = 2'b00;
      #1;
      chk("t6_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      @(negedge clk); #1;
      chk1("t6_wrap_valid", bus.imem_req_valid, 1'b1);
      chk("t6_wrap_addr", bus.imem_req_addr, 32'h0000_0000);
      repeat (3) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk1("t6_rst_no_req", bus.imem_req_valid, 1'b0);
      @(negedge clk); #1;
      chk("t6_rst_addr", bus.imem_req_addr, RESET_PC);
      chk1("t6_rst_inst_valid", bus.inst_valid, 1'b0);
      chk("t6_rst_inst", bus.inst, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      set_stream(RESET_PC);
      #1;
      chk1("t6_restart_valid", bus.imem_req_valid, 1'b1);
      chk("t6_restart_addr", bus.imem_req_addr, RESET_PC);
      wait_inst("t6_restart_wait", 20);
      chk("t6_restart_pc", bus.inst_pc, RESET_PC);
      chk("t6_restart_inst", bus.inst, mem_word(RESET_PC));

      repeat (4) @(negedge clk);
      #1;
      chk1("pops_seen", (pop_cnt != 0), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
